// File: rtl/sram_like_resp_pkg.sv
// sram_like_resp_pkg: constants and helpers shared by the sram-like responder.
package sram_like_resp_pkg;

  // Transfer size encodings (informational on this responder; wstrb governs writes).
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Queue payload is {is_wr, data}; the per-entry countdown lives in the FIFO.
  localparam int unsigned ENTRY_W = DATA_W + 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic              is_wr;
    logic [DATA_W-1:0] data;
  } resp_entry_t;

  // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: in-order outstanding-response queue. Each slot carries a countdown
// loaded with LAT-1 on push; the head may retire once its countdown reaches zero.
module sram_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 33,
  parameter int unsigned LAT   = 2
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_data,
  output logic          o_head_ready,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);

  logic [DW-1:0] r_data [DEPTH];
  logic [CW-1:0] r_cnt  [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  // Every slot counts down each cycle and saturates; a push reloads its slot.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_push && (r_wptr == PW'(i))) begin
          r_cnt[i] <= CNT_INIT;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (i_push) r_data[r_wptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == DEPTH_C);
  assign o_head_data  = r_data[r_rptr];
  assign o_head_ready = !o_empty && (r_cnt[r_rptr] == '0);

endmodule

// File: rtl/sram_like_resp.sv
// sram_like_resp: responder end of the sram-like bus. Accepts requests with addr_ok,
// performs the word access at the accept edge and answers with data_ok/rdata in order.
// Optional feature: define SRAM_RESP_RAND_STALL_EN to gate addr_ok and head retirement
// with a free-running LFSR (timing changes, order and data do not).
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned LAT         = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int unsigned MEM_WORDS = 2 ** MEM_AW;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic              r_ready;
  logic              r_data_ok;
  logic [31:0]       r_rdata;

  logic [MEM_AW-1:0] w_waddr;
  logic              w_accept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_head_ready;
  logic              w_take;
  logic              w_give;
  resp_entry_t       w_push_entry;
  resp_entry_t       w_head_entry;
  logic              w_unused;

  // High address bits alias; byte offset is irrelevant to a word access.
  assign w_waddr  = i_addr[MEM_AW+1:2];
  assign w_unused = ^{i_size, i_addr[31:MEM_AW+2], i_addr[1:0], w_empty};

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Stall source steps every cycle and restarts from the seed on reset.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_lfsr <= LFSR_SEED;
    else           r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_take = r_lfsr[0];
  assign w_give = r_lfsr[1];
`else
  assign w_take = 1'b1;
  assign w_give = 1'b1;
`endif

  // Hold addr_ok low through reset and open it on the first edge after release.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_ready <= 1'b0;
    else           r_ready <= 1'b1;
  end

  // No same-cycle pop bypass: a full queue stays closed until a pop has retired.
  assign o_addr_ok = r_ready & ~w_full & w_take;
  assign w_accept  = i_req & o_addr_ok;
  assign w_pop     = w_head_ready & w_give;

  // Write lanes land at the accept edge so any later-accepted read observes them.
  always_ff @(posedge i_clk) begin
    if (w_accept && i_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[w_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Reads capture the word at accept time; write responses carry zero data.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.is_wr = i_wr;
    w_push_entry.data  = i_wr ? '0 : r_mem[w_waddr];
  end

  sram_resp_fifo #(
    .DEPTH (OUTSTANDING),
    .DW    (ENTRY_W),
    .LAT   (LAT)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_push       (w_accept),
    .i_push_data  (w_push_entry),
    .i_pop        (w_pop),
    .o_head_data  (w_head_entry),
    .o_head_ready (w_head_ready),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Registered response: at most one per cycle, rdata holds between responses.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= w_pop;
      if (w_pop) r_rdata <= w_head_entry.is_wr ? '0 : w_head_entry.data;
    end
  end

  assign o_data_ok = r_data_ok;
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: two responders (LAT=2 and LAT=8, OUTSTANDING=4) checked against a
// transaction-level model: response cycle = max(accept + LAT, previous response + 1),
// addr_ok = out of reset for a cycle and fewer than OUTSTANDING unanswered requests.
module tb_sram_like_resp;

  localparam int MEM_AW = 12;
  localparam int OUT    = 4;
  localparam int NI     = 2;
  localparam int QD     = 8;
  localparam int LAT_A  = 2;
  localparam int LAT_B  = 8;
`ifdef SRAM_RESP_RAND_STALL_EN
  localparam int N_OPS        = 10000;
  localparam int OP_BUDGET    = 60000;
  localparam int DRAIN_BUDGET = 2000;
`else
  localparam int N_OPS        = 400;
  localparam int OP_BUDGET    = 4000;
  localparam int DRAIN_BUDGET = 100;
`endif

  logic        clk;
  logic        resetn;
  logic        req     [NI];
  logic        wr      [NI];
  logic [1:0]  size    [NI];
  logic [3:0]  wstrb   [NI];
  logic [31:0] addr    [NI];
  logic [31:0] wdata   [NI];
  logic        addr_ok [NI];
  logic        data_ok [NI];
  logic [31:0] rdata   [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_like_resp #(.MEM_AW(MEM_AW), .LAT(LAT_A), .OUTSTANDING(OUT)) u_dut_a (
    .i_clk(clk), .i_resetn(resetn), .i_req(req[0]), .i_wr(wr[0]), .i_size(size[0]),
    .i_wstrb(wstrb[0]), .i_addr(addr[0]), .i_wdata(wdata[0]),
    .o_addr_ok(addr_ok[0]), .o_data_ok(data_ok[0]), .o_rdata(rdata[0])
  );

  sram_like_resp #(.MEM_AW(MEM_AW), .LAT(LAT_B), .OUTSTANDING(OUT)) u_dut_b (
    .i_clk(clk), .i_resetn(resetn), .i_req(req[1]), .i_wr(wr[1]), .i_size(size[1]),
    .i_wstrb(wstrb[1]), .i_addr(addr[1]), .i_wdata(wdata[1]),
    .o_addr_ok(addr_ok[1]), .o_data_ok(data_ok[1]), .o_rdata(rdata[1])
  );

  // Reference model state
  int          lat      [NI];
  logic [31:0] mm       [NI][4096];
  logic [31:0] rq_data  [NI][QD];
  int          rq_due   [NI][QD];
  int          rq_h     [NI];
  int          rq_n     [NI];
  int          last_due [NI];
  bit          ready_m  [NI];
  bit          exp_aok  [NI];
  logic [31:0] last_rd  [NI];
  int          n_resp   [NI];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic m_clear(input int i);
    rq_h[i] = 0; rq_n[i] = 0; last_due[i] = 0;
    ready_m[i] = 1'b0; exp_aok[i] = 1'b0; last_rd[i] = '0;
  endtask

  task automatic m_accept(input int i);
    int wa;
    int slot;
    int due;
    logic [31:0] d;
    wa = int'(addr[i][MEM_AW+1:2]);
    d  = '0;
    if (wr[i]) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[i][b]) mm[i][wa][8*b +: 8] = wdata[i][8*b +: 8];
    end else begin
      d = mm[i][wa];
    end
    due = cyc + lat[i];
    if (due <= last_due[i]) due = last_due[i] + 1;
    last_due[i] = due;
    slot = (rq_h[i] + rq_n[i]) % QD;
    rq_data[i][slot] = d;
    rq_due[i][slot]  = due;
    rq_n[i]++;
  endtask

  task automatic m_pop(input int i);
    last_rd[i] = rq_data[i][rq_h[i]];
    rq_h[i] = (rq_h[i] + 1) % QD;
    rq_n[i]--;
  endtask

  task automatic m_check(input int i);
    logic [31:0] hd;
    hd = rq_data[i][rq_h[i]];
    if (data_ok[i]) n_resp[i]++;
`ifndef SRAM_RESP_RAND_STALL_EN
    if (rq_n[i] > 0 && rq_due[i][rq_h[i]] == cyc) begin
      chk($sformatf("data_ok[%0d]@%0d", i, cyc), {31'b0, data_ok[i]}, 32'd1);
      chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], hd);
      m_pop(i);
    end else begin
      chk($sformatf("data_ok_idle[%0d]@%0d", i, cyc), {31'b0, data_ok[i]}, 32'd0);
      chk($sformatf("rdata_hold[%0d]@%0d", i, cyc), rdata[i], last_rd[i]);
    end
    exp_aok[i] = ready_m[i] && (rq_n[i] < OUT);
    chk($sformatf("addr_ok[%0d]@%0d", i, cyc), {31'b0, addr_ok[i]}, {31'b0, exp_aok[i]});
`else
    if (data_ok[i]) begin
      if (rq_n[i] == 0) begin
        chk($sformatf("spurious_resp[%0d]@%0d", i, cyc), {31'b0, data_ok[i]}, 32'd0);
      end else begin
        chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], hd);
        m_pop(i);
      end
    end else begin
      chk($sformatf("rdata_hold[%0d]@%0d", i, cyc), rdata[i], last_rd[i]);
    end
    chk($sformatf("aok_gate[%0d]@%0d", i, cyc),
        {31'b0, addr_ok[i] & ~(ready_m[i] && (rq_n[i] < OUT))}, 32'd0);
    exp_aok[i] = addr_ok[i];
`endif
  endtask

  // One clock: inputs sampled at posedge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (resetn) begin
        if (req[i] && exp_aok[i]) m_accept(i);
        ready_m[i] = 1'b1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) m_check(i);
  endtask

  task automatic drive(input int i, input bit rq, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req[i] = rq; wr[i] = w; addr[i] = a; wstrb[i] = s; wdata[i] = d; size[i] = 2'd2;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Present one request and hold it until accepted; leaves it driven.
  task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    bit acc;
    int b;
    drive(i, 1'b1, w, a, s, d);
    acc = 1'b0;
    b = 0;
    while (!acc && b < 200) begin
      acc = exp_aok[i];
      tick();
      b++;
    end
    chk($sformatf("issue_timeout[%0d]", i), {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    idle_all();
    while ((rq_n[0] + rq_n[1]) != 0 && b < DRAIN_BUDGET) begin
      tick();
      b++;
    end
    chk("drain_timeout", 32'(rq_n[0] + rq_n[1]), 32'd0);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    idle_all();
    for (int i = 0; i < NI; i++) m_clear(i);
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  logic [31:0] w5 [6];
  int          r0, r1, drops, low, k, b, acc_cnt;
  int          ops [NI];
  bit          acc [NI];
  int          idx;
  logic [31:0] a;
  bit          rw;
  logic [3:0]  st;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    lat[0] = LAT_A; lat[1] = LAT_B;
    for (int i = 0; i < NI; i++) begin
      n_resp[i] = 0;
      m_clear(i);
    end
    idle_all();

    // 1: reset held 5 cycles, addr_ok opens on the first cycle after release
    do_reset(5);
    tick();
`ifndef SRAM_RESP_RAND_STALL_EN
    chk("t1_aok_after_release", {31'b0, addr_ok[0]}, 32'd1);
`endif

    // 2: full-word write then read of the same address
    r0 = n_resp[0];
    issue(0, 1'b1, 32'h100, 4'hF, 32'h12345678);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    drain();
    chk("t2_resp_count", 32'(n_resp[0] - r0), 32'd2);
    chk("t2_rdata", rdata[0], 32'h12345678);

    // 3: single-lane write merges into the stored word
    issue(0, 1'b1, 32'h101, 4'b0010, 32'h0000AB00);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    drain();
    chk("t3_rdata", rdata[0], 32'h1234AB78);

    // 4: req held high for 10 cycles of reads
    r0 = n_resp[0]; drops = 0; acc_cnt = 0;
    drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      if (!addr_ok[0]) drops++;
      if (exp_aok[0]) acc_cnt++;
      tick();
    end
    drain();
`ifndef SRAM_RESP_RAND_STALL_EN
    chk("t4_aok_drops", 32'(drops), 32'd0);
    chk("t4_resp_count", 32'(n_resp[0] - r0), 32'd10);
`else
    chk("t4_resp_count", 32'(n_resp[0] - r0), 32'(acc_cnt));
`endif

    // 5: LAT=8 responder, fill then burst of 6 reads through a 4-deep queue
    for (int j = 0; j < 6; j++) begin
      w5[j] = $urandom;
      issue(1, 1'b1, 32'h200 + 32'(4 * j), 4'hF, w5[j]);
    end
    drain();
    r1 = n_resp[1]; low = 0; k = 0; b = 0;
    drive(1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
    while (k < 6 && b < 200) begin
      if (!addr_ok[1]) low++;
      acc[1] = exp_aok[1];
      tick();
      b++;
      if (acc[1]) begin
        k++;
        drive(1, 1'b1, 1'b0, 32'h200 + 32'(4 * k), 4'h0, 32'h0);
      end
    end
    drain();
    chk("t5_resp_count", 32'(n_resp[1] - r1), 32'd6);
    chk("t5_last_rdata", rdata[1], w5[5]);
`ifndef SRAM_RESP_RAND_STALL_EN
    chk("t5_aok_low_cycles", 32'(low), 32'd5);
`endif

    // 6: reset with reads in flight drops them; memory survives
    issue(1, 1'b0, 32'h200, 4'h0, 32'h0);
    issue(1, 1'b0, 32'h204, 4'h0, 32'h0);
    issue(1, 1'b0, 32'h208, 4'h0, 32'h0);
    do_reset(3);
    r0 = n_resp[0]; r1 = n_resp[1];
    repeat (12) tick();
    chk("t6_stale_resp", 32'(n_resp[0] + n_resp[1] - r0 - r1), 32'd0);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    idle_all();
    issue(1, 1'b0, 32'h204, 4'h0, 32'h0);
    drain();
    chk("t6_mem_kept_a", rdata[0], 32'h1234AB78);
    chk("t6_mem_kept_b", rdata[1], w5[1]);

    // Random traffic on both responders; first 16 ops per port initialise the window
    r0 = n_resp[0]; r1 = n_resp[1];
    ops[0] = 0; ops[1] = 0; b = 0;
    while ((ops[0] < N_OPS || ops[1] < N_OPS) && b < OP_BUDGET) begin
      for (int i = 0; i < NI; i++) begin
        if (ops[i] < N_OPS && $urandom_range(3) != 0) begin
          if (ops[i] < 16) begin
            idx = ops[i]; rw = 1'b1; st = 4'hF;
          end else begin
            idx = $urandom_range(15); rw = 1'($urandom_range(1)); st = 4'($urandom);
          end
          a = $urandom;
          a[13:2] = 12'(256 + idx);
          drive(i, 1'b1, rw, a, st, $urandom);
          size[i] = 2'($urandom_range(2));
        end else begin
          drive(i, 1'b0, 1'b0, '0, '0, '0);
        end
        acc[i] = req[i] && exp_aok[i];
      end
      tick();
      b++;
      for (int i = 0; i < NI; i++) if (acc[i]) ops[i]++;
    end
    drain();
    chk("rand_ops_done", {31'b0, (ops[0] >= N_OPS) && (ops[1] >= N_OPS)}, 32'd1);
    chk("rand_no_loss", 32'(n_resp[0] + n_resp[1] - r0 - r1), 32'(ops[0] + ops[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
